// File: rtl/sevenseg_scan_mux_if.sv
// Digit-source / display-side signal bundle for the 7-segment scan mux.
// The master supplies BCD data and controls; the slave drives decoder and anodes.
interface sevenseg_scan_mux_if;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  digit_out;
    logic [3:0]  an_n;
    logic        frame_done;

    modport master (
        output bcd_in,
        output load,
        output blank_lz,
        input  digit_out,
        input  an_n,
        input  frame_done
    );

    modport slave (
        input  bcd_in,
        input  load,
        input  blank_lz,
        output digit_out,
        output an_n,
        output frame_done
    );
endinterface

// File: rtl/sevenseg_scan_mux.sv
// Four-digit time-multiplexed 7-segment driver with frame-aligned
// double buffering, leading-zero blanking and anti-ghost guard time.
module sevenseg_scan_mux #(
    parameter int TICK_DIV = 50000,
    parameter int GUARD    = 2
) (
    input logic              clk,
    input logic              rst_n,
    sevenseg_scan_mux_if.slave bus
);
    localparam int CW  = $clog2(TICK_DIV);
    localparam int CW1 = CW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [3:0]    an_n_q, an_n_d;
    logic [3:0]    dig_q, dig_d;
    logic          fd_q, fd_d;

    logic       tick;
    logic       fb;
    logic       guard;
    logic [3:0] nib;
    logic       lz;

    generate
        if (GUARD == 0) begin : g_noguard
            assign guard = 1'b0;
        end else begin : g_guard
            localparam logic [CW:0] GW = CW1'(GUARD);
            assign guard = {1'b0, cnt_q} < GW;
        end
    endgenerate

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        fb    = tick && (idx_q == 2'd3);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = idx_q + {1'b0, tick};

        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        // A load landing on the boundary itself beats any older pending value
        if (fb) begin
            if (bus.load) begin
                disp_d = bus.bcd_in;
            end else if (pend_v_q) begin
                disp_d = pend_q;
            end
            pend_v_d = 1'b0;
        end else if (bus.load) begin
            pend_d   = bus.bcd_in;
            pend_v_d = 1'b1;
        end

        nib = disp_q[3:0];
        lz  = 1'b0;
        unique case (idx_q)
            2'd0: begin
                nib = disp_q[3:0];
                lz  = 1'b0;
            end
            2'd1: begin
                nib = disp_q[7:4];
                lz  = (disp_q[15:4] == 12'h000);
            end
            2'd2: begin
                nib = disp_q[11:8];
                lz  = (disp_q[15:8] == 8'h00);
            end
            2'd3: begin
                nib = disp_q[15:12];
                lz  = (disp_q[15:12] == 4'h0);
            end
            default: begin
                nib = 4'hF;
                lz  = 1'b0;
            end
        endcase

        dig_d  = (bus.blank_lz && lz) ? 4'hF : nib;
        an_n_d = guard ? 4'hF : ~(4'b0001 << idx_q);
        fd_d   = fb;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            disp_q   <= 16'h0000;
            pend_q   <= 16'h0000;
            pend_v_q <= 1'b0;
            an_n_q   <= 4'hF;
            dig_q    <= 4'hF;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            an_n_q   <= an_n_d;
            dig_q    <= dig_d;
            fd_q     <= fd_d;
        end
    end

    assign bus.an_n       = an_n_q;
    assign bus.digit_out  = dig_q;
    assign bus.frame_done = fd_q;
endmodule
